// File: rtl/double_load_ctrl_if.sv
// Handshake and register-side signal bundle for the split-load sequencing controller.
interface double_load_ctrl_if #(
    parameter int N     = 8,
    parameter int CNT_W = 8
);
    logic               half_valid;
    logic               half_ready;
    logic [N/2-1:0]     half_data;
    logic               full_valid;
    logic               full_ready;
    logic [N-1:0]       full_data;
    logic               reg_load_low;
    logic               reg_load_high;
    logic               reg_load;
    logic [N/2-1:0]     reg_d_half;
    logic [N-1:0]       reg_d;
    logic [N-1:0]       reg_q;
    logic               word_valid;
    logic               word_ready;
    logic [N-1:0]       word;
    logic               busy;
    logic               timeout_err;
    logic [CNT_W-1:0]   word_count;

    // master: the controller; slave: sources, register and downstream consumer.
    modport master (
        input  half_valid, half_data, full_valid, full_data, reg_q, word_ready,
        output half_ready, full_ready, reg_load_low, reg_load_high, reg_load,
               reg_d_half, reg_d, word_valid, word, busy, timeout_err, word_count
    );
    modport slave (
        output half_valid, half_data, full_valid, full_data, reg_q, word_ready,
        input  half_ready, full_ready, reg_load_low, reg_load_high, reg_load,
               reg_d_half, reg_d, word_valid, word, busy, timeout_err, word_count
    );
endinterface

// File: rtl/double_load_ctrl.sv
// Sequences half-word or full-word loads into an external split-load register
// and hands the assembled word downstream over valid/ready.
module double_load_ctrl #(
    parameter int N         = 8,
    parameter bit LOW_FIRST = 1'b1,
    parameter int TIMEOUT   = 15,
    parameter int CNT_W     = 8
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                flush,
    double_load_ctrl_if.master  bus
);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_SECOND, FULL} state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            timer_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        timer_d           = timer_q;
        err_d             = 1'b0;
        cnt_d             = cnt_q;
        bus.half_ready    = 1'b0;
        bus.full_ready    = 1'b0;
        bus.reg_load_low  = 1'b0;
        bus.reg_load_high = 1'b0;
        bus.reg_load      = 1'b0;
        // Readies and strobes stay low while reset or flush is active.
        if (!clear && !flush) begin
            unique case (state_q)
                IDLE: begin
                    bus.full_ready = 1'b1;
                    bus.half_ready = !bus.full_valid;
                    if (bus.full_valid) begin
                        bus.reg_load = 1'b1;
                        state_d      = FULL;
                    end else if (bus.half_valid) begin
                        bus.reg_load_low  = LOW_FIRST;
                        bus.reg_load_high = !LOW_FIRST;
                        state_d           = WAIT_SECOND;
                        timer_d           = '0;
                    end
                end
                WAIT_SECOND: begin
                    bus.half_ready = 1'b1;
                    if (bus.half_valid) begin
                        bus.reg_load_low  = !LOW_FIRST;
                        bus.reg_load_high = LOW_FIRST;
                        state_d           = FULL;
                    end else begin
                        timer_d = timer_q + TW'(1);
                        // Abort on the cycle whose increment would reach TIMEOUT.
                        if (TIMEOUT != 0 && timer_q == TW'(TIMEOUT - 1)) begin
                            state_d = IDLE;
                            timer_d = '0;
                            err_d   = 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (bus.word_ready) begin
                        state_d = IDLE;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
        if (flush) begin
            state_d = IDLE;
            timer_d = '0;
        end
    end

    assign bus.word_valid  = (state_q == FULL) && !clear;
    assign bus.busy        = (state_q != IDLE);
    assign bus.timeout_err = err_q;
    assign bus.word_count  = cnt_q;
    assign bus.reg_d_half  = bus.half_data;
    assign bus.reg_d       = bus.full_data;
    assign bus.word        = bus.reg_q;
endmodule

// File: tb/tb_double_load_ctrl.sv
// Drives two controllers (low-first with timeout 4, high-first without timeout)
// from shared stimulus and compares every cycle against a transaction-level model.
module tb_double_load_ctrl;
    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic       flush = 1'b0;
    logic       hv = 1'b0, fv = 1'b0, wr = 1'b0;
    logic [3:0] hd = '0;
    logic [7:0] fd = '0;
    logic [7:0] rq_a, rq_b;
    int         checks = 0;
    int         errors = 0;

    always #5 clock = ~clock;

    double_load_ctrl_if #(.N(8), .CNT_W(8)) bus_a ();
    double_load_ctrl_if #(.N(8), .CNT_W(8)) bus_b ();

    assign bus_a.half_valid = hv;  assign bus_b.half_valid = hv;
    assign bus_a.half_data  = hd;  assign bus_b.half_data  = hd;
    assign bus_a.full_valid = fv;  assign bus_b.full_valid = fv;
    assign bus_a.full_data  = fd;  assign bus_b.full_data  = fd;
    assign bus_a.word_ready = wr;  assign bus_b.word_ready = wr;
    assign bus_a.reg_q      = rq_a;
    assign bus_b.reg_q      = rq_b;

    double_load_ctrl #(.N(8), .LOW_FIRST(1'b1), .TIMEOUT(4), .CNT_W(8)) dut_a (
        .clock(clock), .clear(clear), .flush(flush), .bus(bus_a));
    double_load_ctrl #(.N(8), .LOW_FIRST(1'b0), .TIMEOUT(0), .CNT_W(8)) dut_b (
        .clock(clock), .clear(clear), .flush(flush), .bus(bus_b));

    // The split-load register the controller drives, sharing the clear net.
    always @(posedge clock or posedge clear) begin
        if (clear) rq_a <= '0;
        else if (bus_a.reg_load) rq_a <= bus_a.reg_d;
        else if (bus_a.reg_load_low) rq_a[3:0] <= bus_a.reg_d_half;
        else if (bus_a.reg_load_high) rq_a[7:4] <= bus_a.reg_d_half;
    end
    always @(posedge clock or posedge clear) begin
        if (clear) rq_b <= '0;
        else if (bus_b.reg_load) rq_b <= bus_b.reg_d;
        else if (bus_b.reg_load_low) rq_b[3:0] <= bus_b.reg_d_half;
        else if (bus_b.reg_load_high) rq_b[7:4] <= bus_b.reg_d_half;
    end

    // Model: phase 0 = nothing held, 1 = one half held, 2 = word on offer.
    bit         lf [2] = '{1'b1, 1'b0};
    int         to [2] = '{4, 0};
    int         m_phase [2];
    logic [3:0] m_first [2];
    int         m_idle  [2];
    logic [7:0] m_word  [2];
    logic [7:0] m_cnt   [2];
    logic       m_err   [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic eval_unit(input int k);
        logic [7:0] ctl_obs, ctl_exp;
        logic [7:0] word_obs, cnt_obs, rd_obs;
        logic [3:0] rdh_obs;
        logic hr, fr, ll, lh, ld, wv;
        if (k == 0) begin
            ctl_obs  = {bus_a.half_ready, bus_a.full_ready, bus_a.reg_load_low, bus_a.reg_load_high,
                        bus_a.reg_load, bus_a.word_valid, bus_a.busy, bus_a.timeout_err};
            word_obs = bus_a.word; cnt_obs = bus_a.word_count;
            rd_obs = bus_a.reg_d; rdh_obs = bus_a.reg_d_half;
        end else begin
            ctl_obs  = {bus_b.half_ready, bus_b.full_ready, bus_b.reg_load_low, bus_b.reg_load_high,
                        bus_b.reg_load, bus_b.word_valid, bus_b.busy, bus_b.timeout_err};
            word_obs = bus_b.word; cnt_obs = bus_b.word_count;
            rd_obs = bus_b.reg_d; rdh_obs = bus_b.reg_d_half;
        end
        if (clear) begin
            m_phase[k] = 0; m_idle[k] = 0; m_cnt[k] = '0; m_err[k] = 1'b0;
        end
        hr = 0; fr = 0; ll = 0; lh = 0; ld = 0; wv = 0;
        if (!clear) begin
            if (m_phase[k] == 0 && !flush) begin
                fr = 1; hr = !fv;
                ld = fv;
                ll = !fv && hv && lf[k];
                lh = !fv && hv && !lf[k];
            end else if (m_phase[k] == 1 && !flush) begin
                hr = 1;
                ll = hv && !lf[k];
                lh = hv && lf[k];
            end
            wv = (m_phase[k] == 2);
        end
        ctl_exp = {hr, fr, ll, lh, ld, wv, 1'(m_phase[k] != 0), m_err[k]};
        check($sformatf("ctl%0d", k), 32'(ctl_obs), 32'(ctl_exp));
        check($sformatf("count%0d", k), 32'(cnt_obs), 32'(m_cnt[k]));
        check($sformatf("pass%0d", k), {20'd0, rd_obs, rdh_obs}, {20'd0, fd, hd});
        if (m_phase[k] == 2 && !clear)
            check($sformatf("word%0d", k), 32'(word_obs), 32'(m_word[k]));

        // Advance to the state seen after the coming rising edge.
        if (clear) return;
        m_err[k] = 1'b0;
        if (flush) begin
            m_phase[k] = 0; m_idle[k] = 0;
        end else if (m_phase[k] == 0) begin
            if (fv) begin
                m_word[k] = fd; m_phase[k] = 2;
            end else if (hv) begin
                m_first[k] = hd; m_phase[k] = 1; m_idle[k] = 0;
            end
        end else if (m_phase[k] == 1) begin
            if (hv) begin
                m_word[k]  = lf[k] ? {hd, m_first[k]} : {m_first[k], hd};
                m_phase[k] = 2;
            end else begin
                m_idle[k]++;
                if (to[k] != 0 && m_idle[k] == to[k]) begin
                    m_phase[k] = 0; m_idle[k] = 0; m_err[k] = 1'b1;
                end
            end
        end else if (wr) begin
            m_phase[k] = 0;
            m_cnt[k]   = m_cnt[k] + 8'd1;
        end
    endtask

    task automatic run(input logic hv_, input logic [3:0] hd_, input logic fv_, input logic [7:0] fd_,
                       input logic wr_, input logic fl_, input logic clr_);
        @(negedge clock);
        hv = hv_; hd = hd_; fv = fv_; fd = fd_; wr = wr_; flush = fl_; clear = clr_;
        #1;
        eval_unit(0);
        eval_unit(1);
        $display("cyc t=%0t hv=%0b hd=%0h fv=%0b fd=%0h wr=%0b fl=%0b clr=%0b | A st=%0d cnt=%0d | B st=%0d cnt=%0d",
                 $time, hv, hd, fv, fd, wr, flush, clear, m_phase[0], m_cnt[0], m_phase[1], m_cnt[1]);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0; m_idle[k] = 0; m_cnt[k] = '0; m_err[k] = 1'b0;
            m_word[k] = '0; m_first[k] = '0;
        end
        run(0, 4'h0, 0, 8'h00, 0, 0, 1);
        run(0, 4'h0, 0, 8'h00, 0, 0, 1);
        run(0, 4'h0, 0, 8'h00, 0, 0, 0);
        // Half pair 0x3 then 0xA: A gives 0xA3, B gives 0x3A.
        run(1, 4'h3, 0, 8'h00, 0, 0, 0);
        run(1, 4'hA, 0, 8'h00, 0, 0, 0);
        run(0, 4'h0, 0, 8'h00, 1, 0, 0);
        run(0, 4'h0, 0, 8'h00, 0, 0, 0);
        // Full and half together: full wins.
        run(1, 4'h7, 1, 8'h5C, 0, 0, 0);
        run(0, 4'h0, 0, 8'h00, 1, 0, 0);
        // One half, then silence: A times out after 4 idle cycles.
        run(1, 4'h5, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 6; i++) run(0, 4'h0, 0, 8'h00, 0, 0, 0);
        run(1, 4'h1, 0, 8'h00, 0, 0, 0);
        run(1, 4'h2, 0, 8'h00, 0, 0, 0);
        run(0, 4'h0, 0, 8'h00, 1, 0, 0);
        run(0, 4'h0, 0, 8'h00, 1, 0, 0);
        // Word held without ready, then flushed with ready high.
        run(0, 4'h0, 1, 8'h96, 0, 0, 0);
        for (int i = 0; i < 5; i++) run(1, 4'h9, 1, 8'h11, 0, 0, 0);
        run(0, 4'h0, 0, 8'h00, 1, 1, 0);
        run(0, 4'h0, 0, 8'h00, 0, 0, 0);
        // Clear while waiting for the second half, then a clean pair.
        run(1, 4'h4, 0, 8'h00, 0, 0, 0);
        run(0, 4'h0, 0, 8'h00, 0, 0, 1);
        run(0, 4'h0, 0, 8'h00, 0, 0, 0);
        run(1, 4'hB, 0, 8'h00, 0, 0, 0);
        run(1, 4'hC, 0, 8'h00, 0, 0, 0);
        run(0, 4'h0, 0, 8'h00, 1, 0, 0);
        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            run(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 3) == 0), 8'($urandom),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 31) == 0));
        end
        run(0, 4'h0, 0, 8'h00, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/double_load_ctrl.md
Name: double_load_ctrl

Overview:
- Sequencing controller for the split-load N-bit register (load_low / load_high / load, D_half / D).
- Accepts half-words from a serial source or full words from a parallel source, each over a valid/ready handshake.
- Drives the register's load strobes in the correct order and presents the assembled word downstream with a valid/ready handshake.
- Adds a second-half timeout, a synchronous flush and a delivered-word counter.

Parameters:
- N, 8: register width; must be even, N >= 2.
- LOW_FIRST, 1: 1 = first accepted half goes to the low half (load_low); 0 = first half goes to the high half.
- TIMEOUT, 15: maximum idle cycles allowed in WAIT_SECOND; 0 disables the timeout. Timer width is clog2(TIMEOUT+1).
- CNT_W, 8: width of word_count.

Ports:
- clock, input, 1: system clock, rising edge.
- clear, input, 1: asynchronous, active-high reset. Also drive the register's clear from the same net.
- flush, input, 1: synchronous abort to IDLE.
- half_valid, input, 1: half-word source valid.
- half_ready, output, 1: half-word source ready.
- half_data, input, N/2: half-word payload; forwarded to reg_d_half.
- full_valid, input, 1: full-word source valid.
- full_ready, output, 1: full-word source ready.
- full_data, input, N: full-word payload; forwarded to reg_d.
- reg_load_low, output, 1: register low-half load strobe.
- reg_load_high, output, 1: register high-half load strobe.
- reg_load, output, 1: register full-word load strobe.
- reg_d_half, output, N/2: equals half_data (combinational).
- reg_d, output, N: equals full_data (combinational).
- reg_q, input, N: register Q.
- word_valid, output, 1: assembled word available.
- word_ready, input, 1: downstream accepts the word.
- word, output, N: equals reg_q.
- busy, output, 1: 1 whenever state != IDLE.
- timeout_err, output, 1: one-cycle pulse on timeout abort.
- word_count, output, CNT_W: count of delivered words; wraps modulo 2^CNT_W.

Behaviour:
- Reset (clear=1, asynchronous): state=IDLE, timer=0, word_count=0, timeout_err=0. All strobes and word_valid deassert combinationally from state.
- States: IDLE, WAIT_SECOND, FULL. Encoding is free.
- Handshake fires when valid && ready on a rising edge. Strobes are combinational (Mealy): strobe = fire && state condition. At most one strobe is high in any cycle.
- IDLE:
  - half_ready=1, full_ready=1.
  - full_valid has priority. It asserts reg_load and goes to FULL; half_ready drops to 0 that cycle, so the half source is not accepted.
  - Else if half_valid: assert the first-half strobe (load_low if LOW_FIRST=1, else load_high). Go to WAIT_SECOND with timer=0.
- WAIT_SECOND:
  - half_ready=1, full_ready=0.
  - If half_valid: assert the opposite-half strobe and go to FULL.
  - Else timer increments. When TIMEOUT != 0 and the timer reaches TIMEOUT, go to IDLE and timeout_err=1 for exactly one cycle (the first IDLE cycle). The partially written register contents are left as-is and overwritten by the next load.
- FULL:
  - word_valid=1, half_ready=0, full_ready=0.
  - word (=reg_q) holds the new word, because the register loaded on the edge entering FULL.
  - On word_ready: go to IDLE and increment word_count. word_valid holds until accepted.
- Latency:
  - Full path: word_valid is high the cycle after the full_data handshake.
  - Half path: word_valid is high the cycle after the second-half handshake.
  - Back-to-back: next input can be accepted one cycle after the word_ready handshake (IDLE cycle); no FULL->load bypass.
- flush:
  - Takes priority over every transition: next state IDLE, timer=0.
  - All ready outputs and strobes are forced to 0 in the flush cycle.
  - word_count does not increment, even if word_ready=1 in FULL. No timeout_err.
- clear mid-operation (any state): immediate IDLE, counter reset. No strobes while clear=1.
- Simultaneous timeout and half_valid in the same WAIT_SECOND cycle: the half is accepted; no error.

Test Plan:
- N=8, LOW_FIRST=1: half 0x3 then 0xA, word_ready=1 -> reg_load_low, then reg_load_high; word=0xA3, word_valid 1 cycle; word_count=1.
- LOW_FIRST=0: halves 0x3, 0xA -> word=0x3A; load_high strobe precedes load_low.
- IDLE with full_valid=1 (full_data=0x5C) and half_valid=1 together -> only reg_load; half_ready=0; word=0x5C next cycle.
- TIMEOUT=4: one half, then no input -> IDLE after 4 idle cycles; timeout_err single pulse; word_count unchanged; next pair 0x1, 0x2 -> word 0x21.
- FULL with word_ready=0 for 5 cycles -> word_valid held, half_ready=full_ready=0; then flush=1 with word_ready=1 -> IDLE, count not incremented.
- Assert clear in WAIT_SECOND -> state IDLE, busy=0, word_count=0 asynchronously; deassert and a pair completes normally.
